// File: rtl/uart_pkg.sv
// Shared UART definitions: FSM state encoding, oversampling constants and
// the baud divider calculation. The transmitter reuses this package.
package uart_pkg;

  localparam int unsigned OVERSAMPLE = 16;
  localparam int unsigned SAMPLE_MID = 8;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP,
    WAIT_HIGH
  } state_t;

  // Clocks per oversample tick, rounded to nearest, never below 1.
  function automatic int unsigned calc_div(input int unsigned clk_freq,
                                           input int unsigned baud,
                                           input int unsigned os);
    int unsigned d;
    d = (clk_freq + (baud * os) / 2) / (baud * os);
    if (d < 1) d = 1;
    return d;
  endfunction

endpackage

// File: rtl/uart_baud_tick.sv
// Oversample tick generator: one-cycle tick every DIV clocks, restartable
// so that tick phase aligns to a detected start edge.
module uart_baud_tick #(
  parameter int unsigned DIV = 1
) (
  input  logic clk,
  input  logic rst_n,
  input  logic restart,
  output logic tick
);

  localparam int unsigned W = (DIV > 1) ? $clog2(DIV) : 1;

  logic [W-1:0] cnt;

  assign tick = (cnt == W'(DIV - 1));

  // Free-running divider, cleared on restart and after each tick.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (restart || tick) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + W'(1);
    end
  end

endmodule

// File: rtl/uart_rx_os.sv
// 16x oversampling UART receiver with 2-FF input synchroniser, 3-sample
// majority vote, false-start rejection and framing-error reporting.
// Optional even parity bit enabled by defining UART_PARITY_EN.
module uart_rx_os #(
  parameter int unsigned CLK_FREQ   = 50_000_000,
  parameter int unsigned BAUD       = 115200,
  parameter int unsigned OVERSAMPLE = 16
) (
  input  logic       i_Clk,
  input  logic       i_Rst,
  input  logic       i_Rx,
  output logic       o_fDone,
  output logic [7:0] o_Data,
  output logic       o_fErr,
  output logic       o_fBusy
);

  import uart_pkg::*;

  localparam int unsigned DIV = calc_div(CLK_FREQ, BAUD, OVERSAMPLE);

  localparam logic [3:0] T_EARLY = 4'(SAMPLE_MID - 1);
  localparam logic [3:0] T_MID   = 4'(SAMPLE_MID);
  localparam logic [3:0] T_LATE  = 4'(SAMPLE_MID + 1);
  localparam logic [3:0] T_LAST  = 4'(OVERSAMPLE - 1);

  logic       rx_meta, rx_sync;
  logic       tick, restart;
  logic       maj;

  state_t     state, state_nxt;
  logic [3:0] tick_cnt, tick_cnt_nxt;
  logic [2:0] bit_idx, bit_idx_nxt;
  logic [7:0] shift, shift_nxt;
  logic       s_early, s_early_nxt;
  logic       s_mid, s_mid_nxt;
  logic       vote, vote_nxt;
  logic [7:0] data_q, data_nxt;
  logic       done_q, done_nxt;
  logic       err_q, err_nxt;
`ifdef UART_PARITY_EN
  logic       par_err, par_err_nxt;
`endif

  uart_baud_tick #(
    .DIV(DIV)
  ) u_tick (
    .clk     (i_Clk),
    .rst_n   (i_Rst),
    .restart (restart),
    .tick    (tick)
  );

  // Input synchroniser; resets to the idle (high) line level.
  always_ff @(posedge i_Clk or negedge i_Rst) begin
    if (!i_Rst) begin
      rx_meta <= '1;
      rx_sync <= '1;
    end else begin
      rx_meta <= i_Rx;
      rx_sync <= rx_meta;
    end
  end

  // Majority of the two stored early samples and the live late sample.
  assign maj = (s_early & s_mid) | (s_early & rx_sync) | (s_mid & rx_sync);

  // State and datapath registers.
  always_ff @(posedge i_Clk or negedge i_Rst) begin
    if (!i_Rst) begin
      state    <= IDLE;
      tick_cnt <= '0;
      bit_idx  <= '0;
      shift    <= '0;
      s_early  <= '0;
      s_mid    <= '0;
      vote     <= '0;
      data_q   <= '0;
      done_q   <= '0;
      err_q    <= '0;
`ifdef UART_PARITY_EN
      par_err  <= '0;
`endif
    end else begin
      state    <= state_nxt;
      tick_cnt <= tick_cnt_nxt;
      bit_idx  <= bit_idx_nxt;
      shift    <= shift_nxt;
      s_early  <= s_early_nxt;
      s_mid    <= s_mid_nxt;
      vote     <= vote_nxt;
      data_q   <= data_nxt;
      done_q   <= done_nxt;
      err_q    <= err_nxt;
`ifdef UART_PARITY_EN
      par_err  <= par_err_nxt;
`endif
    end
  end

  // Next-state and output decode. Start detection counts as tick 0 of the
  // start bit, so the counter is loaded with 1 and the divider restarted.
  always_comb begin
    state_nxt    = state;
    tick_cnt_nxt = tick_cnt;
    bit_idx_nxt  = bit_idx;
    shift_nxt    = shift;
    s_early_nxt  = s_early;
    s_mid_nxt    = s_mid;
    vote_nxt     = vote;
    data_nxt     = data_q;
    done_nxt     = 1'b0;
    err_nxt      = 1'b0;
    restart      = 1'b0;
`ifdef UART_PARITY_EN
    par_err_nxt  = par_err;
`endif

    unique case (state)
      IDLE: begin
        if (!rx_sync) begin
          state_nxt    = START;
          tick_cnt_nxt = 4'd1;
          bit_idx_nxt  = '0;
          restart      = 1'b1;
`ifdef UART_PARITY_EN
          par_err_nxt  = 1'b0;
`endif
        end
      end

      WAIT_HIGH: begin
        if (tick) begin
          if (!rx_sync) begin
            tick_cnt_nxt = '0;
          end else if (tick_cnt == T_LAST) begin
            tick_cnt_nxt = '0;
            state_nxt    = IDLE;
          end else begin
            tick_cnt_nxt = tick_cnt + 4'd1;
          end
        end
      end

      default: begin
        if (tick) begin
          tick_cnt_nxt = tick_cnt + 4'd1;
          if (tick_cnt == T_EARLY) s_early_nxt = rx_sync;
          if (tick_cnt == T_MID)   s_mid_nxt   = rx_sync;
          if (tick_cnt == T_LATE)  vote_nxt    = maj;

          case (state)
            START: begin
              if (tick_cnt == T_LAST) begin
                state_nxt = vote ? IDLE : DATA;
              end
            end

            DATA: begin
              if (tick_cnt == T_LATE) begin
                shift_nxt = {maj, shift[7:1]};
              end
              if (tick_cnt == T_LAST) begin
                if (bit_idx == 3'd7) begin
`ifdef UART_PARITY_EN
                  state_nxt = PARITY;
`else
                  state_nxt = STOP;
`endif
                end else begin
                  bit_idx_nxt = bit_idx + 3'd1;
                end
              end
            end

`ifdef UART_PARITY_EN
            PARITY: begin
              if (tick_cnt == T_LATE) begin
                par_err_nxt = (maj != ^shift);
              end
              if (tick_cnt == T_LAST) begin
                state_nxt = STOP;
              end
            end
`endif

            STOP: begin
              if (tick_cnt == T_LATE) begin
`ifdef UART_PARITY_EN
                if (maj && !par_err) begin
`else
                if (maj) begin
`endif
                  data_nxt     = shift;
                  done_nxt     = 1'b1;
                  state_nxt    = IDLE;
                  tick_cnt_nxt = '0;
                end else begin
                  err_nxt      = 1'b1;
                  state_nxt    = WAIT_HIGH;
                  tick_cnt_nxt = '0;
                end
              end
            end

            default: begin
            end
          endcase
        end
      end
    endcase
  end

  assign o_fDone = done_q;
  assign o_fErr  = err_q;
  assign o_Data  = data_q;
  assign o_fBusy = (state != IDLE);

endmodule
